// File: rtl/mesi_pkg.sv
// ----------------------------------------------------------------------
// mesi_pkg: shared encodings for the MESI L1 cache and its lane aligner.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package mesi_pkg;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_E = 2'b01,
    MESI_S = 2'b10,
    MESI_M = 2'b11
  } mesi_state_t;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_UPGR = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_NONE = 2'b11
  } bus_cmd_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WB   = 2'd1;
  localparam state_t ST_ARB  = 2'd2;
  localparam state_t ST_RESP = 2'd3;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  function automatic logic is_owned(input mesi_state_t s);
    return (s == MESI_M) || (s == MESI_E);
  endfunction

endpackage

`default_nettype wire

// File: rtl/l1_lane_align.sv
// ----------------------------------------------------------------------
// l1_lane_align: load extract/extend and store byte-merge by size/offset.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module l1_lane_align
  import mesi_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        size,
  input  logic [1:0]        offset,
  input  logic [DATA_W-1:0] line,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);

  logic [4:0]        sh_b;
  logic [4:0]        sh_h;
  logic [7:0]        sel_b;
  logic [15:0]       sel_h;
  logic [DATA_W-1:0] mask;

  // Halfwords are taken from the naturally aligned half containing offset.
  assign sh_b  = {offset, 3'b000};
  assign sh_h  = {offset[1], 4'b0000};
  assign sel_b = line[sh_b +: 8];
  assign sel_h = line[sh_h +: 16];

  always_comb begin
    load_data = '0;
    mask      = '0;
    merged    = line;
    case (size)
      SZ_B, SZ_BU: begin
        load_data = {{(DATA_W-8){sel_b[7] & (size == SZ_B)}}, sel_b};
        mask      = {{(DATA_W-8){1'b0}}, 8'hFF} << sh_b;
        merged    = (line & ~mask) | ((wdata << sh_b) & mask);
      end
      SZ_H, SZ_HU: begin
        load_data = {{(DATA_W-16){sel_h[15] & (size == SZ_H)}}, sel_h};
        mask      = {{(DATA_W-16){1'b0}}, 16'hFFFF} << sh_h;
        merged    = (line & ~mask) | ((wdata << sh_h) & mask);
      end
      SZ_W: begin
        load_data = line;
        merged    = wdata;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/l1_mesi_cache_param.sv
// ----------------------------------------------------------------------
// l1_mesi_cache_param: direct-mapped write-back L1 with MESI snooping.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module l1_mesi_cache_param
  import mesi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_LINES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [2:0]        core_size,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [1:0]        bus_cmd,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_resp_valid,
  input  logic [DATA_W-1:0] bus_resp_data,
  input  logic              bus_shared,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic              wb_ready,
  input  logic              snoop_valid,
  input  logic [1:0]        snoop_cmd,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              snoop_hit,
  output logic [DATA_W-1:0] snoop_data,
  output logic              snoop_flush
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 2;

  mesi_state_t        state_q [NUM_LINES];
  mesi_state_t        state_d [NUM_LINES];
  logic [TAG_W-1:0]   tag_q   [NUM_LINES];
  logic [TAG_W-1:0]   tag_d   [NUM_LINES];
  logic [DATA_W-1:0]  data_q  [NUM_LINES];
  logic [DATA_W-1:0]  data_d  [NUM_LINES];
  state_t             fsm_q, fsm_d;
  bus_cmd_t           cmd_q, cmd_d;
  logic [ADDR_W-3:0]  req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;

  logic [INDEX_W-1:0] c_idx, s_idx, r_idx;
  logic [TAG_W-1:0]   c_tag, s_tag, r_tag;
  mesi_state_t        c_state, s_state;
  logic               c_hit, s_match, collide, up_kill, size_ok, unused_snoop_offset;
  bus_cmd_t           cmd_eff;
  logic [DATA_W-1:0]  lane_line, load_data, merged;

  assign c_idx   = core_addr[INDEX_W+1:2];
  assign c_tag   = core_addr[ADDR_W-1:INDEX_W+2];
  assign s_idx   = snoop_addr[INDEX_W+1:2];
  assign s_tag   = snoop_addr[ADDR_W-1:INDEX_W+2];
  assign r_idx   = req_addr_q[INDEX_W-1:0];
  assign r_tag   = req_addr_q[ADDR_W-3:INDEX_W];
  assign c_state = state_q[c_idx];
  assign s_state = state_q[s_idx];
  assign unused_snoop_offset = ^snoop_addr[1:0];

  assign c_hit   = (c_state != MESI_I) && (tag_q[c_idx] == c_tag);
  assign s_match = snoop_valid && (s_state != MESI_I) && (tag_q[s_idx] == s_tag);
  assign collide = s_match && (s_idx == c_idx);
  assign size_ok = core_size inside {SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU};

  // A pending upgrade whose S copy is being invalidated must fetch the line.
  assign up_kill = s_match && (s_idx == r_idx) && (s_tag == r_tag) && (cmd_q == BUS_UPGR) &&
                   ((snoop_cmd == BUS_UPGR) || (snoop_cmd == BUS_RDX));
  assign cmd_eff = up_kill ? BUS_RDX : cmd_q;

  assign lane_line = (fsm_q == ST_RESP) ? bus_resp_data : data_q[c_idx];

  l1_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .size      (core_size),
    .offset    (core_addr[1:0]),
    .line      (lane_line),
    .wdata     (core_wdata),
    .load_data (load_data),
    .merged    (merged)
  );

  assign core_ready  = (fsm_q == ST_IDLE) && core_req && c_hit &&
                       ((core_we == OP_LOAD) || (is_owned(c_state) && !collide));
  assign core_rdata  = (core_ready && core_we == OP_LOAD) ? load_data : '0;
  assign snoop_hit   = s_match;
  assign snoop_data  = s_match ? data_q[s_idx] : '0;
  assign snoop_flush = s_match && is_owned(s_state) &&
                       ((snoop_cmd == BUS_RD) || (snoop_cmd == BUS_RDX));
  assign bus_req     = (fsm_q == ST_ARB) && !reset;
  assign bus_cmd     = (bus_req && bus_grant) ? cmd_eff : BUS_NONE;
  assign bus_addr    = (bus_req && bus_grant) ? {req_addr_q, 2'b00} : '0;
  assign wb_valid    = (fsm_q == ST_WB) && !reset;
  assign wb_addr     = wb_valid ? wb_addr_q : '0;
  assign wb_data     = wb_valid ? wb_data_q : '0;

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    data_d     = data_q;
    fsm_d      = fsm_q;
    cmd_d      = cmd_q;
    req_addr_d = req_addr_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    if (s_match) begin
      case (snoop_cmd)
        BUS_RD:   if (is_owned(s_state)) state_d[s_idx] = MESI_S;
        BUS_RDX:  state_d[s_idx] = MESI_I;
        BUS_UPGR: if (s_state == MESI_S) state_d[s_idx] = MESI_I;
        default:  ;
      endcase
    end

    case (fsm_q)
      ST_IDLE: begin
        if (core_ready && core_we == OP_STORE) begin
          if (size_ok) begin
            data_d[c_idx]  = merged;
            state_d[c_idx] = MESI_M;
          end
        end else if (core_req && !core_ready && !(core_we == OP_STORE && collide)) begin
          req_addr_d = core_addr[ADDR_W-1:2];
          cmd_d      = (core_we == OP_LOAD) ? BUS_RD : (c_hit ? BUS_UPGR : BUS_RDX);
          fsm_d      = ST_ARB;
          if (!c_hit && c_state == MESI_M) begin
            wb_addr_d = {tag_q[c_idx], c_idx, 2'b00};
            wb_data_d = data_q[c_idx];
            fsm_d     = ST_WB;
          end
        end
      end
      ST_WB: if (wb_ready) fsm_d = ST_ARB;
      ST_ARB: begin
        cmd_d = cmd_eff;
        if (bus_grant) fsm_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus_resp_valid) begin
          fsm_d = ST_IDLE;
          case (cmd_q)
            BUS_RD: begin
              data_d[r_idx]  = bus_resp_data;
              tag_d[r_idx]   = r_tag;
              state_d[r_idx] = bus_shared ? MESI_S : MESI_E;
            end
            BUS_RDX: begin
              data_d[r_idx]  = merged;
              tag_d[r_idx]   = r_tag;
              state_d[r_idx] = MESI_M;
            end
            default: state_d[r_idx] = MESI_M;
          endcase
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= MESI_I;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
      fsm_q      <= ST_IDLE;
      cmd_q      <= BUS_NONE;
      req_addr_q <= '0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      fsm_q      <= fsm_d;
      cmd_q      <= cmd_d;
      req_addr_q <= req_addr_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_l1_mesi_cache_param.sv
// ----------------------------------------------------------------------
// tb_l1_mesi_cache_param: directed vectors and coherence sequences.
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_l1_mesi_cache_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_req, core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        core_ready, bus_req, bus_grant;
  logic [1:0]  bus_cmd;
  logic [31:0] bus_addr, bus_resp_data;
  logic        bus_resp_valid, bus_shared;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_addr, wb_data;
  logic        snoop_valid, snoop_hit, snoop_flush;
  logic [1:0]  snoop_cmd;
  logic [31:0] snoop_addr, snoop_data;

  always #5 clk = ~clk;

  l1_mesi_cache_param #(.ADDR_W(32), .DATA_W(32), .NUM_LINES(64)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_size(core_size),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_ready(core_ready),
    .bus_req(bus_req), .bus_grant(bus_grant), .bus_cmd(bus_cmd), .bus_addr(bus_addr),
    .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data), .bus_shared(bus_shared),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .snoop_valid(snoop_valid), .snoop_cmd(snoop_cmd), .snoop_addr(snoop_addr),
    .snoop_hit(snoop_hit), .snoop_data(snoop_data), .snoop_flush(snoop_flush)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [2:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    core_req = req; core_we = we; core_size = sz; core_addr = a; core_wdata = wd;
  endtask

  // Waits (bounded) for bus_req, grants, answers, and checks the replayed hit.
  task automatic bus_txn(input logic [1:0] exp_cmd, input logic [31:0] exp_addr,
                         input logic [31:0] resp, input logic shared,
                         input logic snp, input logic [1:0] snp_cmd);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      @(negedge clk);
      if (bus_req) begin
        found = 1'b1;
        break;
      end
    end
    check("bus_req_seen", 32'(found), 32'd1);
    bus_grant = 1'b1;
    if (snp) begin
      snoop_valid = 1'b1; snoop_cmd = snp_cmd; snoop_addr = exp_addr;
    end
    #1;
    check("bus_cmd", 32'(bus_cmd), 32'(exp_cmd));
    check("bus_addr", bus_addr, exp_addr);
    step();
    bus_grant = 1'b0; snoop_valid = 1'b0;
    bus_resp_valid = 1'b1; bus_resp_data = resp; bus_shared = shared;
    @(negedge clk);
    check("resp_ready_low", 32'(core_ready), 32'd0);
    step();
    bus_resp_valid = 1'b0; bus_shared = 1'b0;
    @(negedge clk);
    check("replay_ready", 32'(core_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE};
    vecs[1]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE};
    vecs[2]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDEAD};
    vecs[3]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h0000BEEF};
    vecs[4]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h00000000};
    vecs[6]  = '{1'b1, 3'b001, 32'h102, 32'h1234,     32'h00000000};
    vecs[7]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h1234BEEF};
    vecs[8]  = '{1'b1, 3'b111, 32'h100, 32'hFFFFFFFF, 32'h00000000};
    vecs[9]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h1234BEEF};
    vecs[10] = '{1'b0, 3'b000, 32'h101, 32'h0,        32'hFFFFFFBE};

    reset = 1'b1;
    drive_core(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    bus_grant = 1'b0; bus_resp_valid = 1'b0; bus_resp_data = 32'h0; bus_shared = 1'b0;
    wb_ready = 1'b0; snoop_valid = 1'b0; snoop_cmd = 2'b11; snoop_addr = 32'h0;
    step(); step();
    @(negedge clk);
    check("rst_bus_cmd", 32'(bus_cmd), 32'h3);
    check("rst_bus_req", 32'(bus_req), 32'h0);
    check("rst_wb_valid", 32'(wb_valid), 32'h0);
    check("rst_core_ready", 32'(core_ready), 32'h0);
    check("rst_core_rdata", core_rdata, 32'h0);
    check("rst_snoop_flush", 32'(snoop_flush), 32'h0);
    reset = 1'b0;

    // Cold load miss, exclusive fill.
    step();
    drive_core(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    @(negedge clk);
    check("t1_miss_ready", 32'(core_ready), 32'h0);
    bus_txn(2'b00, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0, 2'b11);
    check("t1_rdata", core_rdata, 32'hDEADBEEF);

    // Hit-path vectors on the 0x100 line.
    for (int i = 0; i < 11; i++) begin
      step();
      drive_core(1'b1, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(core_ready), 32'h1);
      check($sformatf("vec%0d_rdata", i), core_rdata, vecs[i].exp_rdata);
    end

    // Conflict miss evicts the dirty 0x100 line; wb_ready withheld for a while.
    step();
    drive_core(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    check("t3_miss_ready", 32'(core_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      check($sformatf("t3_wb_valid%0d", k), 32'(wb_valid), 32'h1);
      check($sformatf("t3_wb_addr%0d", k), wb_addr, 32'h100);
      check($sformatf("t3_wb_data%0d", k), wb_data, 32'h1234BEEF);
      check($sformatf("t3_no_bus_req%0d", k), 32'(bus_req), 32'h0);
    end
    wb_ready = 1'b1;
    bus_txn(2'b00, 32'h200, 32'h55AA1234, 1'b0, 1'b0, 2'b11);
    wb_ready = 1'b0;
    check("t3_rdata", core_rdata, 32'h55AA1234);
    check("t3_wb_done", 32'(wb_valid), 32'h0);

    // Snoop BusRd on our E line, then again on the resulting S line.
    step();
    drive_core(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    snoop_valid = 1'b1; snoop_cmd = 2'b00; snoop_addr = 32'h200;
    #1;
    check("t4_hit", 32'(snoop_hit), 32'h1);
    check("t4_flush", 32'(snoop_flush), 32'h1);
    check("t4_data", snoop_data, 32'h55AA1234);
    step();
    check("t4_s_hit", 32'(snoop_hit), 32'h1);
    check("t4_s_noflush", 32'(snoop_flush), 32'h0);
    step();
    snoop_valid = 1'b0;

    // Shared fill then byte store: BusUpgr, ack data ignored.
    drive_core(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    @(negedge clk);
    check("tu_miss_ready", 32'(core_ready), 32'h0);
    bus_txn(2'b00, 32'h104, 32'h01020304, 1'b1, 1'b0, 2'b11);
    check("tu_rdata", core_rdata, 32'h01020304);
    step();
    drive_core(1'b1, 1'b1, 3'b000, 32'h104, 32'h77);
    @(negedge clk);
    check("tu_s_store_ready", 32'(core_ready), 32'h0);
    bus_txn(2'b01, 32'h104, 32'hFFFFFFFF, 1'b0, 1'b0, 2'b11);
    step();
    drive_core(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    @(negedge clk);
    check("tu_after_upgr", core_rdata, 32'h01020377);

    // Upgrade races a BusRdX snoop in the grant cycle: becomes BusRdX.
    step();
    drive_core(1'b1, 1'b1, 3'b010, 32'h200, 32'hCAFEF00D);
    @(negedge clk);
    check("t5_ready_low", 32'(core_ready), 32'h0);
    bus_txn(2'b10, 32'h200, 32'h0BADF00D, 1'b0, 1'b1, 2'b10);
    step();
    drive_core(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    @(negedge clk);
    check("t5_rdata", core_rdata, 32'hCAFEF00D);

    // Evict the now-M line, then reset during RESP.
    step();
    drive_core(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    @(negedge clk);
    check("t6_miss_ready", 32'(core_ready), 32'h0);
    step();
    @(negedge clk);
    check("t6_wb_valid", 32'(wb_valid), 32'h1);
    check("t6_wb_addr", wb_addr, 32'h200);
    check("t6_wb_data", wb_data, 32'hCAFEF00D);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    @(negedge clk);
    check("t6_bus_req", 32'(bus_req), 32'h1);
    bus_grant = 1'b1;
    step();
    bus_grant = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    check("t6_rst_bus_req", 32'(bus_req), 32'h0);
    check("t6_rst_wb_valid", 32'(wb_valid), 32'h0);
    check("t6_rst_bus_cmd", 32'(bus_cmd), 32'h3);
    reset = 1'b0;
    drive_core(1'b1, 1'b0, 3'b010, 32'h104, 32'h0);
    snoop_valid = 1'b1; snoop_cmd = 2'b00; snoop_addr = 32'h104;
    #1;
    check("t6_core_miss", 32'(core_ready), 32'h0);
    check("t6_snoop_miss", 32'(snoop_hit), 32'h0);
    check("t6_no_flush", 32'(snoop_flush), 32'h0);
    step();
    drive_core(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
    snoop_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
